// File: rtl/peak_pkg.sv
// peak_pkg: shared definitions for the peak reader.
//   - Frame geometry: peaks per frame and field widths.
//   - Avalon register addresses and STATUS bit positions.
//   - peak_frame_t: one captured frame (time counter + PEAKS freq/amp pairs).
package peak_pkg;

    localparam int PEAKS      = 6;   // peak pairs per frame, at most 14
    localparam int FREQ_WIDTH = 10;  // frequency index width, at most 16
    localparam int AMPL_WIDTH = 16;  // signed amplitude width, at most 16
    localparam int TIME_WIDTH = 32;  // frame counter width, at most 32

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_TIME   = 4'd1;
    localparam logic [3:0] ADDR_PEAK0  = 4'd2;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_EMPTY_BIT = 30;
    localparam int STAT_FULL_BIT  = 29;
    localparam int STAT_COUNT_MSB = 7;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]            counter;
        logic [PEAKS-1:0][FREQ_WIDTH-1:0] freqs;
        logic [PEAKS-1:0][AMPL_WIDTH-1:0] amps;
    } peak_frame_t;

    // Packs one peak into a PEAK_k register word: freq zero-extended in the
    // upper half, amplitude sign-extended in the lower half.
    function automatic logic [31:0] peak_word(logic [FREQ_WIDTH-1:0] freq,
                                              logic [AMPL_WIDTH-1:0] amp);
        return {16'(freq), 16'(signed'(amp))};
    endfunction

endpackage

// File: rtl/peak_reader_if.sv
// peak_reader_if: Avalon-MM slave bus between the HPS bridge and peak_reader.
//   chipselect/read/write/address/writedata : master -> slave
//   readdata : registered read data, valid the cycle after chipselect & read
//   irq      : level interrupt, high while frames are queued
// Handshake: a read or write is a single-cycle command sampled on the rising
// clock edge while chipselect is high; there is no waitrequest, and read data
// always appears exactly one cycle after the sampled read.
interface peak_reader_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/valid_edge_sync.sv
// valid_edge_sync: brings the asynchronous valid strobe into the clock domain
// and produces a one-cycle registered pulse per rising edge.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset
//   async_i : asynchronous level strobe
//   pulse_o : one-cycle pulse, registered, two cycles after the synchronized rise
module valid_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            // Only a low-to-high transition of the synchronized level fires,
            // so a held-high strobe yields exactly one pulse.
            pulse_q <= sync2_q & ~sync3_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/peak_reader.sv
// peak_reader: captures each frame published by the peak finder into a small
// frame FIFO and lets the HPS drain it over Avalon-MM.
//   CLOCK_50      : system clock
//   reset_n       : asynchronous active-low reset
//   valid_in      : frame strobe from the peaks stage (asynchronous)
//   counter_in    : frame time counter
//   freqs_in      : PEAKS frequency indices
//   amplitudes_in : PEAKS signed amplitudes
//   bus           : Avalon slave (STATUS/TIME/PEAK_k reads, overflow clear
//                   and pop writes) plus irq
module peak_reader
    import peak_pkg::*;
#(
    parameter int DEPTH = 8  // frames, power of two, 2..128
) (
    input  logic                             CLOCK_50,
    input  logic                             reset_n,
    input  logic                             valid_in,
    input  logic [TIME_WIDTH-1:0]            counter_in,
    input  logic [PEAKS-1:0][FREQ_WIDTH-1:0] freqs_in,
    input  logic [PEAKS-1:0][AMPL_WIDTH-1:0] amplitudes_in,
    peak_reader_if.slave                     bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    peak_frame_t        mem_q [DEPTH];
    peak_frame_t        in_frame;
    peak_frame_t        head;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic               push;
    logic               push_ok;
    logic               pop_req;
    logic               pop_ok;
    logic               clr_ovf;
    logic               empty;
    logic               full;
    logic               rd_sel;
    logic               wr_sel;

    valid_edge_sync u_sync (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .async_i (valid_in),
        .pulse_o (push)
    );

    assign in_frame.counter = counter_in;
    assign in_frame.freqs   = freqs_in;
    assign in_frame.amps    = amplitudes_in;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    assign rd_sel  = bus.chipselect & bus.read;
    assign wr_sel  = bus.chipselect & bus.write;
    assign pop_req = wr_sel && (bus.address == ADDR_TIME);
    assign clr_ovf = wr_sel && (bus.address == ADDR_STATUS) && bus.writedata[31];

    // A simultaneous pop frees the slot the push needs, even when full.
    assign pop_ok  = pop_req && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over a clear in the same cycle.
        if (clr_ovf)             ovf_d = 1'b0;
        if (push && !push_ok)    ovf_d = 1'b1;
    end

    // Read mux uses the current head, so a read alongside a pop returns the
    // pre-pop frame. readdata holds its value between reads.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_sel) begin
            readdata_d = '0;
            if (bus.address == ADDR_STATUS) begin
                readdata_d[STAT_OVF_BIT]       = ovf_q;
                readdata_d[STAT_EMPTY_BIT]     = empty;
                readdata_d[STAT_FULL_BIT]      = full;
                readdata_d[STAT_COUNT_MSB:0]   = 8'(count_q);
            end else if (!empty) begin
                if (bus.address == ADDR_TIME) begin
                    readdata_d = 32'(head.counter);
                end
                for (int k = 0; k < PEAKS; k++) begin
                    if (bus.address == 4'(int'(ADDR_PEAK0) + k)) begin
                        readdata_d = peak_word(head.freqs[k], head.amps[k]);
                    end
                end
            end
        end
    end

    // irq follows the registered count, so it trails a count change by one cycle.
    assign irq_d = (count_q != '0);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    // Frame storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem_q[wr_ptr_q] <= in_frame;
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_peak_reader.sv
module tb_peak_reader;
    import peak_pkg::*;

    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic                             valid_in = 1'b0;
    logic [TIME_WIDTH-1:0]            counter_in = '0;
    logic [PEAKS-1:0][FREQ_WIDTH-1:0] freqs_in = '0;
    logic [PEAKS-1:0][AMPL_WIDTH-1:0] amplitudes_in = '0;

    peak_reader_if bus();

    peak_reader #(.DEPTH(DEPTH)) dut (
        .CLOCK_50      (clk),
        .reset_n       (rst_n),
        .valid_in      (valid_in),
        .counter_in    (counter_in),
        .freqs_in      (freqs_in),
        .amplitudes_in (amplitudes_in),
        .bus           (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned t;
        int unsigned f[PEAKS];
        int          a[PEAKS];
    } ref_frame_t;

    ref_frame_t ref_q[$];
    bit         ref_ovf = 1'b0;

    function automatic logic [31:0] model_read(input int addr);
        logic [31:0] r;
        r = 32'h0;
        if (addr == 0) begin
            if (ref_ovf)              r = r | 32'h8000_0000;
            if (ref_q.size() == 0)    r = r | 32'h4000_0000;
            if (ref_q.size() == DEPTH) r = r | 32'h2000_0000;
            r = r + 32'(ref_q.size());
        end else if (ref_q.size() != 0) begin
            if (addr == 1) r = 32'(ref_q[0].t);
            else if (addr >= 2 && addr < 2 + PEAKS)
                r = (32'(ref_q[0].f[addr-2]) << 16) | (32'(ref_q[0].a[addr-2]) & 32'h0000_FFFF);
        end
        return r;
    endfunction

    function automatic void model_push(input ref_frame_t fr);
        if (ref_q.size() == DEPTH) ref_ovf = 1'b1;
        else ref_q.push_back(fr);
    endfunction

    function automatic void model_pop();
        if (ref_q.size() != 0) void'(ref_q.pop_front());
    endfunction

    function automatic ref_frame_t rand_frame(input int unsigned t);
        ref_frame_t fr;
        fr.t = t;
        for (int k = 0; k < PEAKS; k++) begin
            fr.f[k] = $urandom_range(0, (1 << FREQ_WIDTH) - 1);
            fr.a[k] = int'($urandom_range(0, (1 << AMPL_WIDTH) - 1)) - (1 << (AMPL_WIDTH - 1));
        end
        return fr;
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          addr_q[$];

    initial begin : monitor
        logic [31:0] e;
        int          a;
        forever begin
            @(posedge clk);
            if (bus.chipselect === 1'b1 && bus.read === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("unexpected_read", bus.readdata, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    check($sformatf("read_addr%0d", a), bus.readdata, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_frame(input ref_frame_t fr);
        counter_in = TIME_WIDTH'(fr.t);
        for (int k = 0; k < PEAKS; k++) begin
            freqs_in[k]      = FREQ_WIDTH'(fr.f[k]);
            amplitudes_in[k] = AMPL_WIDTH'(fr.a[k]);
        end
    endtask

    task automatic send_frame(input ref_frame_t fr, input int hold);
        @(negedge clk);
        drive_frame(fr);
        valid_in = 1'b1;
        model_push(fr);
        repeat (hold) @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_read(input int addr);
        @(negedge clk);
        exp_q.push_back(model_read(addr));
        addr_q.push_back(addr);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 4'(addr);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 4'(addr);
        bus.writedata  = data;
        if (addr == 1) model_pop();
        if (addr == 0 && data[31]) ref_ovf = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic drain_all();
        while (ref_q.size() != 0) begin
            bus_read(1);
            bus_read(2 + int'($urandom_range(0, PEAKS - 1)));
            bus_write(1, 32'h0);
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        ref_frame_t fr;
        int         cyc;

        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_irq", 32'(bus.irq), 32'h0);
        check("reset_readdata", bus.readdata, 32'h0);
        bus_read(0);
        bus_read(1);
        bus_read(15);

        // Directed frame from the plan
        fr.t = 5;
        fr.f = '{3, 40, 90, 150, 300, 500};
        fr.a = '{-2, 7, 100, -1, 0, 32767};
        @(negedge clk);
        drive_frame(fr);
        valid_in = 1'b1;
        model_push(fr);
        cyc = 0;
        while (bus.irq !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("irq_rise", 32'(bus.irq), 32'h1);
        check("irq_within_5", 32'(cyc <= 5), 32'h1);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 2 + PEAKS; a++) bus_read(a);

        // Pop, then pop while empty
        bus_write(1, 32'h0);
        bus_read(0);
        @(negedge clk);
        check("irq_after_pop", 32'(bus.irq), 32'h0);
        bus_write(1, 32'h0);
        bus_read(0);
        bus_read(1);

        // Nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(rand_frame(i), 3);
        bus_read(0);
        drain_all();
        bus_read(0);
        bus_write(0, 32'h0000_0001);
        bus_read(0);
        bus_write(0, 32'h8000_0000);
        bus_read(0);

        // Full FIFO with push coinciding with a pop
        for (int i = 0; i < DEPTH; i++) send_frame(rand_frame($urandom), 3);
        bus_read(0);
        fr = rand_frame(32'hCAFE_0001);
        @(negedge clk);
        drive_frame(fr);
        valid_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 4'd1;
        bus.writedata  = 32'h0;
        model_pop();
        model_push(fr);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        valid_in       = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(0);
        drain_all();
        bus_read(0);

        // Level held high: one frame only
        send_frame(rand_frame(77), 100);
        bus_read(0);
        bus_read(1);

        // Randomized mix of pushes, pops, reads and writes
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 1: send_frame(rand_frame($urandom), int'($urandom_range(3, 6)));
                2:    bus_write(1, $urandom);
                3:    bus_read(int'($urandom_range(0, 15)));
                default: bus_write(int'($urandom_range(0, 1)) * 9, $urandom);
            endcase
        end
        bus_read(0);
        drain_all();
        bus_read(0);
        bus_write(0, 32'h8000_0000);

        // Reset with three frames queued
        for (int i = 0; i < 3; i++) send_frame(rand_frame(100 + i), 3);
        bus_read(0);
        @(negedge clk);
        check("irq_before_reset", 32'(bus.irq), 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_async_irq", 32'(bus.irq), 32'h0);
        check("reset_async_readdata", bus.readdata, 32'h0);
        ref_q.delete();
        ref_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(0);
        bus_read(1);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/peak_reader.md
Name: peak_reader

Overview:
- Reader side of the peak-extraction stage: each time the peak finder publishes a new frame, this block captures it. A frame is the time counter plus PEAKS (freq, amplitude) pairs.
- Captured frames are queued in a small frame FIFO.
- The HPS drains the FIFO over an Avalon-MM slave: one 32-bit word per field, plus an explicit pop. irq flags pending data.
- Sits between the peaks stage and the lightweight HPS bridge; the fingerprint hashing software consumes its output.

Parameters:
- PEAKS, `PEAKS (6), peak pairs per frame; must be ≤ 14.
- FREQ_WIDTH, `FREQ_WIDTH, frequency-index width; must be ≤ 16.
- AMPL_WIDTH, `FINAL_AMPL_WIDTH, signed amplitude width; must be ≤ 16.
- TIME_WIDTH, `TIME_COUNTER_WIDTH, frame counter width; must be ≤ 32.
- DEPTH, 8, FIFO depth in frames; must be a power of two and ≤ 128.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  the same level strobe that clocks the peaks stage; asynchronous to CLOCK_50.
- counter_in  in  TIME_WIDTH  frame time counter from the peaks stage.
- freqs_in  in  FREQ_WIDTH x PEAKS  peak frequency indices.
- amplitudes_in  in  AMPL_WIDTH x PEAKS  signed peak amplitudes.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  4  word address.
- writedata  in  32  write data.
- readdata  out  32  read data.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count = 0, overflow = 0, readdata = 0, irq = 0, sync/edge registers = 0.
- valid_in path:
  - Two-flop synchronizer into CLOCK_50, then a rising-edge detect.
  - The peaks stage updates its outputs on the valid_in edge, so data is stable by the time the edge is detected.
  - Capture (push) happens on the cycle after the edge detect: about 3–4 CLOCK_50 cycles after the valid_in rise.
  - Exactly one push per valid_in rising edge. A level held high produces no further pushes.
- Push when full: frame dropped, FIFO contents unchanged, overflow set (sticky).
- Pop when empty: ignored; no state change.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - This also applies when full: the pop frees a slot and the push is accepted with no overflow.
- Pointers wrap modulo DEPTH; count is tracked separately (0..DEPTH) to distinguish full from empty.
- Register map, read (one-cycle latency, readdata registered; chipselect & read sampled on cycle N, data valid on cycle N+1):
  - addr 0 STATUS: [31] overflow, [30] empty, [29] full, [7:0] count, other bits 0.
  - addr 1 TIME: head frame counter, zero-extended.
  - addr 2+k PEAK_k (k < PEAKS): [31:16] freq zero-extended; [15:0] amplitude sign-extended.
  - Other addresses read 0. TIME and PEAK_k read 0 when empty.
- Register map, write (takes effect the cycle chipselect & write is sampled):
  - addr 0: if writedata[31] = 1, clear overflow. If a push overflows in the same cycle, set wins.
  - addr 1: pop head frame (writedata ignored).
  - Other addresses: ignored.
- Reads are non-destructive. A read and a pop in the same cycle returns the pre-pop head.
- irq = ~empty, registered; updates one cycle after a count change.
- Reset mid-operation: all frames discarded. A valid_in edge in flight during reset is lost.

Decomposition:
- Package peak_pkg:
  - Address constants ADDR_STATUS = 0, ADDR_TIME = 1, ADDR_PEAK0 = 2.
  - STATUS bit positions.
  - typedef peak_frame_t: packed struct of counter, freqs[PEAKS], amps[PEAKS].
- Sub-module valid_edge_sync: 2-flop synchronizer plus rising-edge pulse, async active-low reset.
- FIFO storage is an array of peak_frame_t inline in peak_reader (DEPTH x frame, register-based).

Test Plan:
- Reset, then read addr 0 → readdata = 0x4000_0000 (empty), irq = 0; read addr 1 → 0.
- One valid_in pulse with counter = 5, freqs = {3,40,90,150,300,500}, amps = {-2,7,100,-1,0,32767} → within 5 cycles irq = 1 and STATUS count = 1. Then TIME reads 5, PEAK_0 reads 0x0003_FFFE, PEAK_5 reads 0x01F4_7FFF.
- Pop: write addr 1 → next STATUS = 0x4000_0000 and irq = 0 one cycle later. Second pop while empty → status unchanged.
- Nine valid_in pulses (counters 1..9) with DEPTH = 8, no pops → STATUS = 0xA000_0008 (overflow, full). Draining 8 frames yields TIME 1..8. Write addr 0 with 0x8000_0000 → overflow clears.
- FIFO full; a valid_in edge is timed so its push coincides with a pop write → count stays 8, no overflow, and the new frame is last out after draining.
- valid_in held high for 100 cycles → exactly one frame pushed. reset_n asserted with 3 frames queued → count = 0, irq = 0 immediately (async).
